arith_block_accumulator: RTL and testbench

//  Downstream consumer of the 4-bit combinational arithmetic unit. Takes one operand pair plus its results per beat:
//  - sum (5b), diff (4b), half (4b), product (8b).

---
 rtl/arith_pkg.sv | 29 ++
 rtl/arith_sat_add.sv | 20 ++
 rtl/arith_block_accumulator.sv | 179 +++++++++++++++++
 tb/tb_arith_block_accumulator.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared widths, FSM state type and a generic saturating-add helper for the
// block accumulator and its sub-modules.
package arith_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned SUM_W  = 5;
    localparam int unsigned PROD_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

    // Returns {sat, result}; result is clamped to 2^w-1 when the true sum exceeds it.
    function automatic logic [32:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] full;
        logic [31:0] max_val;
        full    = {1'b0, a} + {1'b0, b};
        max_val = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        if (full > {1'b0, max_val}) begin
            return {1'b1, max_val};
        end
        return {1'b0, full[31:0]};
    endfunction

endpackage

// File: rtl/arith_sat_add.sv
// Combinational W-bit saturating adder: clamps to all-ones on carry-out and
// flags the clamp on o_sat.
module arith_sat_add
    import arith_pkg::*;
#(
    parameter int unsigned W = 12
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum,
    output logic         o_sat
);

    logic [W:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b};
    assign o_sat  = w_full[W];
    assign o_sum  = w_full[W] ? {W{1'b1}} : w_full[W-1:0];

endmodule

// File: rtl/arith_block_accumulator.sv
// Accumulates BLOCK_LEN arithmetic-unit beats into one saturating block summary
// on a valid/ready port. Define ARITH_CHECK_EN to cross-check every beat.
module arith_block_accumulator
    import arith_pkg::*;
#(
    parameter int unsigned BLOCK_LEN = 8,
    parameter int unsigned ACC_W     = 12,
    localparam int unsigned CNT_W    = $clog2(BLOCK_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    input  logic [SUM_W-1:0]  in_sum,
    input  logic [OP_W-1:0]   in_diff,
    input  logic [OP_W-1:0]   in_half,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc_prod,
    output logic [ACC_W-1:0]  out_acc_sum,
    output logic [CNT_W-1:0]  out_borrows,
    output logic              out_sat,
    output logic              out_chk_err
);

    acc_state_t       r_state, w_state_next;
    logic [CNT_W-1:0] r_count, r_borrows;
    logic [ACC_W-1:0] r_acc_prod, r_acc_sum;
    logic             r_sat;
    logic [OP_W-1:0]  r_diff, r_half;
    logic [ACC_W-1:0] r_out_acc_prod, r_out_acc_sum;
    logic [CNT_W-1:0] r_out_borrows;
    logic             r_out_sat;

    logic             w_accept, w_first, w_last, w_borrow;
    logic [ACC_W-1:0] w_prod_ext, w_sum_ext, w_add_prod, w_add_sum;
    logic             w_sat_prod, w_sat_sum;
    logic [ACC_W-1:0] w_nxt_prod, w_nxt_sum;
    logic [CNT_W-1:0] w_nxt_count, w_nxt_borrows;
    logic             w_nxt_sat;
    logic             w_unused_beat;

    assign in_ready   = (r_state != DONE);
    assign out_valid  = (r_state == DONE);
    assign w_accept   = in_valid && in_ready;
    assign w_first    = (r_state == IDLE);
    assign w_borrow   = (in_a < in_b);
    assign w_prod_ext = ACC_W'(in_prod);
    assign w_sum_ext  = ACC_W'(in_sum);

    arith_sat_add #(.W(ACC_W)) u_add_prod (
        .i_a   (r_acc_prod),
        .i_b   (w_prod_ext),
        .o_sum (w_add_prod),
        .o_sat (w_sat_prod)
    );

    arith_sat_add #(.W(ACC_W)) u_add_sum (
        .i_a   (r_acc_sum),
        .i_b   (w_sum_ext),
        .o_sum (w_add_sum),
        .o_sat (w_sat_sum)
    );

    // The first beat of a block loads rather than adds, so no clear cycle is needed.
    assign w_nxt_prod    = w_first ? w_prod_ext : w_add_prod;
    assign w_nxt_sum     = w_first ? w_sum_ext : w_add_sum;
    assign w_nxt_sat     = w_first ? 1'b0 : (r_sat | w_sat_prod | w_sat_sum);
    assign w_nxt_count   = w_first ? CNT_W'(1) : (r_count + CNT_W'(1));
    assign w_nxt_borrows = (w_first ? '0 : r_borrows) + CNT_W'(w_borrow);
    assign w_last        = (w_nxt_count == CNT_W'(BLOCK_LEN));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE, ACCUM: begin
                if (w_accept) begin
                    w_state_next = w_last ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count        <= '0;
            r_borrows      <= '0;
            r_acc_prod     <= '0;
            r_acc_sum      <= '0;
            r_sat          <= 1'b0;
            r_diff         <= '0;
            r_half         <= '0;
            r_out_acc_prod <= '0;
            r_out_acc_sum  <= '0;
            r_out_borrows  <= '0;
            r_out_sat      <= 1'b0;
        end else if (w_accept) begin
            r_count    <= w_nxt_count;
            r_borrows  <= w_nxt_borrows;
            r_acc_prod <= w_nxt_prod;
            r_acc_sum  <= w_nxt_sum;
            r_sat      <= w_nxt_sat;
            r_diff     <= in_diff;
            r_half     <= in_half;
            if (w_last) begin
                r_out_acc_prod <= w_nxt_prod;
                r_out_acc_sum  <= w_nxt_sum;
                r_out_borrows  <= w_nxt_borrows;
                r_out_sat      <= w_nxt_sat;
            end
        end
    end

    assign out_acc_prod  = r_out_acc_prod;
    assign out_acc_sum   = r_out_acc_sum;
    assign out_borrows   = r_out_borrows;
    assign out_sat       = r_out_sat;
    // Captured for observability only; nothing downstream consumes them.
    assign w_unused_beat = ^{r_diff, r_half};

`ifdef ARITH_CHECK_EN
    logic w_beat_err, w_in_unknown, w_nxt_chk, r_chk_err, r_out_chk_err;

    assign w_in_unknown = $isunknown({in_a, in_b, in_sum, in_diff, in_half, in_prod});

    always_comb begin
        w_beat_err = (in_sum != (SUM_W'(in_a) + SUM_W'(in_b)))
                   || (in_prod != (PROD_W'(in_a) * PROD_W'(in_b)))
                   || (in_half != (in_a >> 1))
                   || (in_diff != (in_a - in_b));
        if (w_in_unknown) begin
            w_beat_err = 1'b1;
        end
    end

    assign w_nxt_chk = (w_first ? 1'b0 : r_chk_err) | w_beat_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_chk_err     <= 1'b0;
            r_out_chk_err <= 1'b0;
        end else if (w_accept) begin
            r_chk_err <= w_nxt_chk;
            if (w_last) begin
                r_out_chk_err <= w_nxt_chk;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_accept) begin
            assert (!w_in_unknown)
                else $warning("arith_block_accumulator: X/Z on accepted beat inputs");
        end
    end

    assign out_chk_err = r_out_chk_err;
`else
    assign out_chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_arith_block_accumulator.sv
// Directed self-checking bench: three parameterisations of the block accumulator
// share data inputs; each has its own in_valid so only one accepts at a time.
module tb_arith_block_accumulator;

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_a, in_b, in_diff, in_half;
    logic [4:0]  in_sum;
    logic [7:0]  in_prod;
    logic        out_ready;
    logic        v8, v5, v1;

    logic        rdy8, ov8, sat8, chk8;
    logic [11:0] prod8, sum8;
    logic [3:0]  bor8;
    logic        rdy5, ov5, sat5, chk5;
    logic [9:0]  prod5, sum5;
    logic [2:0]  bor5;
    logic        rdy1, ov1, sat1, chk1;
    logic [11:0] prod1, sum1;
    logic [0:0]  bor1;

    int checks = 0;
    int errors = 0;

    arith_block_accumulator #(.BLOCK_LEN(8), .ACC_W(12)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8),
        .in_a(in_a), .in_b(in_b), .in_sum(in_sum), .in_diff(in_diff),
        .in_half(in_half), .in_prod(in_prod), .out_valid(ov8), .out_ready(out_ready),
        .out_acc_prod(prod8), .out_acc_sum(sum8), .out_borrows(bor8),
        .out_sat(sat8), .out_chk_err(chk8)
    );

    arith_block_accumulator #(.BLOCK_LEN(5), .ACC_W(10)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(v5), .in_ready(rdy5),
        .in_a(in_a), .in_b(in_b), .in_sum(in_sum), .in_diff(in_diff),
        .in_half(in_half), .in_prod(in_prod), .out_valid(ov5), .out_ready(out_ready),
        .out_acc_prod(prod5), .out_acc_sum(sum5), .out_borrows(bor5),
        .out_sat(sat5), .out_chk_err(chk5)
    );

    arith_block_accumulator #(.BLOCK_LEN(1), .ACC_W(12)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1),
        .in_a(in_a), .in_b(in_b), .in_sum(in_sum), .in_diff(in_diff),
        .in_half(in_half), .in_prod(in_prod), .out_valid(ov1), .out_ready(out_ready),
        .out_acc_prod(prod1), .out_acc_sum(sum1), .out_borrows(bor1),
        .out_sat(sat1), .out_chk_err(chk1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            end
    endtask

    task automatic set_valid(input int which, input logic v);
        case (which)
            8: v8 = v;
            5: v5 = v;
            default: v1 = v;
        endcase
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input bit bad_prod);
        in_a    = a;
        in_b    = b;
        in_sum  = 5'(a) + 5'(b);
        in_diff = a - b;
        in_half = a >> 1;
        in_prod = bad_prod ? 8'd14 : (8'(a) * 8'(b));
    endtask

    // Sends n beats, gap idle cycles between beats; returns one negedge after
    // the final beat was presented, with in_valid low.
    task automatic send(input int which, input int n, input logic [3:0] a,
                        input logic [3:0] b, input int gap, input bit bad_first);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            drive(a, b, bad_first && (i == 0));
            set_valid(which, 1'b1);
            @(negedge clk);
            if (gap > 0 && i < n - 1) begin
                set_valid(which, 1'b0);
                repeat (gap) @(negedge clk);
            end
        end
        set_valid(which, 1'b0);
    endtask

    initial begin
        logic exp_chk;
        rst_n = 1'b0; out_ready = 1'b0; v8 = 1'b0; v5 = 1'b0; v1 = 1'b0;
        drive(4'd0, 4'd0, 1'b0);
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_out_valid", 32'(ov8), 32'd0);
        check("rst_in_ready", 32'(rdy8), 32'd1);
        check("rst_acc_prod", 32'(prod8), 32'd0);
        check("rst_acc_sum", 32'(sum8), 32'd0);
        check("rst_borrows", 32'(bor8), 32'd0);
        check("rst_sat", 32'(sat8), 32'd0);
        check("rst_chk_err", 32'(chk8), 32'd0);
        rst_n = 1'b1;

        // 8 back-to-back beats A=3,B=5, held in DONE by out_ready=0
        send(8, 8, 4'd3, 4'd5, 0, 1'b0);
        check("blk_out_valid", 32'(ov8), 32'd1);
        check("blk_acc_prod", 32'(prod8), 32'd120);
        check("blk_acc_sum", 32'(sum8), 32'd64);
        check("blk_borrows", 32'(bor8), 32'd8);
        check("blk_sat", 32'(sat8), 32'd0);

        // Backpressure: offered beats must be refused and summary held
        for (int i = 0; i < 4; i++) begin
            drive(4'd1, 4'd1, 1'b0);
            v8 = 1'b1;
            @(negedge clk);
            check("bp_in_ready", 32'(rdy8), 32'd0);
            check("bp_out_valid", 32'(ov8), 32'd1);
            check("bp_acc_prod", 32'(prod8), 32'd120);
        end
        v8 = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("rel_out_valid", 32'(ov8), 32'd0);
        check("rel_in_ready", 32'(rdy8), 32'd1);
        check("rel_hold_sum", 32'(sum8), 32'd64);

        // Gapped input, one beat every third cycle
        send(8, 8, 4'd3, 4'd5, 2, 1'b0);
        check("gap_out_valid", 32'(ov8), 32'd1);
        check("gap_acc_prod", 32'(prod8), 32'd120);
        check("gap_acc_sum", 32'(sum8), 32'd64);
        check("gap_borrows", 32'(bor8), 32'd8);
        @(negedge clk);
        check("gap_valid_drop", 32'(ov8), 32'd0);

        // Reset after 3 beats of a block discards them
        send(8, 3, 4'd7, 4'd9, 0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(ov8), 32'd0);
        check("mid_rst_in_ready", 32'(rdy8), 32'd1);
        check("mid_rst_acc_prod", 32'(prod8), 32'd0);
        send(8, 8, 4'd2, 4'd1, 0, 1'b0);
        check("clean_out_valid", 32'(ov8), 32'd1);
        check("clean_acc_prod", 32'(prod8), 32'd16);
        check("clean_acc_sum", 32'(sum8), 32'd24);
        check("clean_borrows", 32'(bor8), 32'd0);

        // ACC_W=10, BLOCK_LEN=5 saturation then a clean block
        send(5, 5, 4'd15, 4'd15, 0, 1'b0);
        check("sat_out_valid", 32'(ov5), 32'd1);
        check("sat_acc_prod", 32'(prod5), 32'd1023);
        check("sat_acc_sum", 32'(sum5), 32'd150);
        check("sat_flag", 32'(sat5), 32'd1);
        check("sat_borrows", 32'(bor5), 32'd0);
        send(5, 5, 4'd1, 4'd2, 0, 1'b0);
        check("unsat_acc_prod", 32'(prod5), 32'd10);
        check("unsat_acc_sum", 32'(sum5), 32'd15);
        check("unsat_flag", 32'(sat5), 32'd0);
        check("unsat_borrows", 32'(bor5), 32'd5);

        // BLOCK_LEN=1: a summary after every beat
        send(1, 1, 4'd7, 4'd9, 0, 1'b0);
        check("bl1a_out_valid", 32'(ov1), 32'd1);
        check("bl1a_acc_prod", 32'(prod1), 32'd63);
        check("bl1a_acc_sum", 32'(sum1), 32'd16);
        check("bl1a_borrows", 32'(bor1), 32'd1);
        send(1, 1, 4'd9, 4'd2, 0, 1'b0);
        check("bl1b_out_valid", 32'(ov1), 32'd1);
        check("bl1b_acc_prod", 32'(prod1), 32'd18);
        check("bl1b_acc_sum", 32'(sum1), 32'd11);
        check("bl1b_borrows", 32'(bor1), 32'd0);

        // Corrupted product on the first beat of a block
`ifdef ARITH_CHECK_EN
        exp_chk = 1'b1;
`else
        exp_chk = 1'b0;
`endif
        send(8, 8, 4'd3, 4'd5, 0, 1'b1);
        check("bad_out_valid", 32'(ov8), 32'd1);
        check("bad_acc_prod", 32'(prod8), 32'd119);
        check("bad_chk_err", 32'(chk8), 32'(exp_chk));
        send(8, 8, 4'd3, 4'd5, 0, 1'b0);
        check("good_chk_err", 32'(chk8), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
